// File: rtl/vga_fb_draw_engine.sv
// Rectangle-fill / single-pixel-read engine feeding the SDRAM frame buffer source port.
// One command at a time; each command becomes a stream of src_write or one src_read handshake.
`timescale 1ns/1ps

`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif

// state   | meaning
// IDLE    | cmd_ready=1, latch and clip an incoming command
// FILL    | issue one src_write per accepted pixel, row by row
// RD_REQ  | hold src_read until the frame buffer accepts it
// RD_WAIT | wait for src_readdatavalid or the timeout
// DONE    | one-cycle done pulse (plus rd_valid for reads)
module vga_fb_draw_engine #(
  parameter int AVS_DW     = 16,
  parameter int RGB_SIZE   = 12,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [`H_SIZE-1:0]  cmd_x0,
  input  logic [`H_SIZE-1:0]  cmd_x1,
  input  logic [`V_SIZE-1:0]  cmd_y0,
  input  logic [`V_SIZE-1:0]  cmd_y1,
  input  logic [RGB_SIZE-1:0] cmd_color,
  output logic                busy,
  output logic                done,
  output logic [AVS_DW-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_err,
  output logic                src_read,
  output logic                src_write,
  output logic [`H_SIZE-1:0]  src_x,
  output logic [`V_SIZE-1:0]  src_y,
  output logic [AVS_DW-1:0]   src_writedata,
  input  logic [AVS_DW-1:0]   src_readdata,
  input  logic                src_readdatavalid,
  input  logic                src_rdy
);

  localparam int HW = `H_SIZE;
  localparam int VW = `V_SIZE;
  localparam int TW = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

  localparam logic [HW:0] X_LIM = (HW+1)'(`H_DISPLAY);
  localparam logic [VW:0] Y_LIM = (VW+1)'(`V_DISPLAY);
  localparam logic [HW:0] X_MAX = (HW+1)'(`H_DISPLAY - 1);
  localparam logic [VW:0] Y_MAX = (VW+1)'(`V_DISPLAY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         x0_q, x0_d;
  logic [HW-1:0]         x1_q, x1_d;
  logic [VW-1:0]         y1_q, y1_d;
  logic [HW-1:0]         cur_x_q, cur_x_d;
  logic [VW-1:0]         cur_y_q, cur_y_d;
  logic [RGB_SIZE-1:0]   color_q, color_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [AVS_DW-1:0]     rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_err_q, rd_err_d;

  // Compares are done one bit wider so bounds at or past the display edge never wrap.
  logic [HW:0]   x0_w, x1_w;
  logic [VW:0]   y0_w, y1_w;
  logic [HW-1:0] x1_clip;
  logic [VW-1:0] y1_clip;
  logic          xy0_oob;
  logic          fill_empty;

  always_comb begin
    x0_w       = {1'b0, cmd_x0};
    x1_w       = {1'b0, cmd_x1};
    y0_w       = {1'b0, cmd_y0};
    y1_w       = {1'b0, cmd_y1};
    x1_clip    = (x1_w > X_MAX) ? X_MAX[HW-1:0] : cmd_x1;
    y1_clip    = (y1_w > Y_MAX) ? Y_MAX[VW-1:0] : cmd_y1;
    xy0_oob    = (x0_w >= X_LIM) || (y0_w >= Y_LIM);
    fill_empty = xy0_oob || (cmd_x0 > x1_clip) || (cmd_y0 > y1_clip);
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    color_d    = color_q;
    tmo_d      = tmo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    src_write  = 1'b0;
    src_read   = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          x1_d    = x1_clip;
          y1_d    = y1_clip;
          cur_x_d = cmd_x0;
          cur_y_d = cmd_y0;
          color_d = cmd_color;
          if (!cmd_op) begin
            state_d = fill_empty ? DONE : FILL;
          end else if (xy0_oob) begin
            state_d    = DONE;
            rd_data_d  = '0;
            rd_valid_d = 1'b1;
            rd_err_d   = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end

      FILL: begin
        src_write = 1'b1;
        if (src_rdy) begin
          if (cur_x_q == x1_q) begin
            if (cur_y_q == y1_q) begin
              state_d = DONE;
            end else begin
              cur_x_d = x0_q;
              cur_y_d = cur_y_q + VW'(1);
            end
          end else begin
            cur_x_d = cur_x_q + HW'(1);
          end
        end
      end

      RD_REQ: begin
        src_read = 1'b1;
        if (src_rdy) begin
          state_d = RD_WAIT;
          tmo_d   = TW'(RD_TIMEOUT);
        end
      end

      RD_WAIT: begin
        if (src_readdatavalid) begin
          state_d    = DONE;
          rd_data_d  = src_readdata;
          rd_valid_d = 1'b1;
        end else if (tmo_q == '0) begin
          state_d    = DONE;
          rd_data_d  = '0;
          rd_valid_d = 1'b1;
          rd_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      color_q    <= '0;
      tmo_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      color_q    <= color_d;
      tmo_q      <= tmo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Payload comes straight from the held registers, so it cannot move while src_rdy=0.
  assign src_x         = cur_x_q;
  assign src_y         = cur_y_q;
  assign src_writedata = AVS_DW'(color_q);
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_vga_fb_draw_engine.sv
// Self-checking bench for vga_fb_draw_engine: directed vector table, hand-written reset
// sequence, then randomized commands checked against a pixel-list reference model.
`timescale 1ns/1ps

`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif

module tb_vga_fb_draw_engine;
  localparam int AVS_DW     = 16;
  localparam int RGB_SIZE   = 12;
  localparam int RD_TIMEOUT = 255;
  localparam int HD         = `H_DISPLAY;
  localparam int VD         = `V_DISPLAY;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_op = 1'b0;
  logic [`H_SIZE-1:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [`V_SIZE-1:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [RGB_SIZE-1:0] cmd_color = '0;
  logic                busy, done, rd_valid, rd_err, src_read, src_write;
  logic [AVS_DW-1:0]   rd_data, src_writedata;
  logic [`H_SIZE-1:0]  src_x;
  logic [`V_SIZE-1:0]  src_y;
  logic [AVS_DW-1:0]   src_readdata = '0;
  logic                src_readdatavalid = 1'b0;
  logic                src_rdy = 1'b0;

  vga_fb_draw_engine #(.AVS_DW(AVS_DW), .RGB_SIZE(RGB_SIZE), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .src_read(src_read), .src_write(src_write), .src_x(src_x), .src_y(src_y),
    .src_writedata(src_writedata), .src_readdata(src_readdata),
    .src_readdatavalid(src_readdatavalid), .src_rdy(src_rdy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {int x; int y; int d; int c;} pix_t;
  pix_t wq[$];
  pix_t eq[$];

  int   done_cnt, done_cyc, rdv_cnt, first_req, ra_cyc;
  bit   ra_pend;
  logic done_rdv, done_rde, done_rdy;
  logic [AVS_DW-1:0] done_rdd;
  int   rdy_mode = 0, rd_lat = 0, rd_val = 0;
  bit   stray = 1'b0;

  logic prev_stall = 1'b0;
  logic [37:0] prev_req;

  // Bus monitor: sampled mid-cycle, records accepted writes and completion events.
  always @(negedge sys_clk) begin
    chk("busy_xor_ready", busy ^ cmd_ready, 1);
    if (src_write && src_read) chk("wr_rd_exclusive", 1, 0);
    if (prev_stall && !sys_rst)
      chk("hold_while_stalled", {src_write, src_read, src_x, src_y, src_writedata}, prev_req);
    prev_stall = (src_write || src_read) && !src_rdy;
    prev_req   = {src_write, src_read, src_x, src_y, src_writedata};
    if ((src_write || src_read) && first_req < 0) first_req = cyc;
    if (src_write && src_rdy) wq.push_back('{int'(src_x), int'(src_y), int'(src_writedata), cyc});
    if (src_read && src_rdy) begin ra_cyc = cyc; ra_pend = 1'b1; end
    if (rd_valid) rdv_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_rdv = rd_valid;
      done_rde = rd_err;
      done_rdd = rd_data;
      done_rdy = cmd_ready;
    end
  end

  // Frame buffer model: src_rdy pattern, read responder, optional stray data strobes.
  always @(posedge sys_clk) begin
    #1;
    case (rdy_mode)
      0:       src_rdy = 1'b1;
      1:       src_rdy = ~src_rdy;
      default: src_rdy = 1'($urandom_range(0, 1));
    endcase
    src_readdatavalid = 1'b0;
    src_readdata      = '0;
    if (ra_pend && rd_lat > 0 && cyc == ra_cyc + rd_lat) begin
      src_readdatavalid = 1'b1;
      src_readdata      = AVS_DW'(rd_val);
      ra_pend           = 1'b0;
    end else if (stray && ((src_read && !src_rdy) || src_write)) begin
      src_readdatavalid = 1'b1;
      src_readdata      = 16'hDEAD;
    end
  end

  task automatic run_cmd(input bit op, input int x0, input int x1, input int y0, input int y1,
                         input int color, input int mode, input int lat, input int val,
                         input bit st, output int nw, output int lx, output int ly,
                         output bit err, output int rdat);
    int  acc, g, xe, ye;
    bit  oob;
    eq.delete();
    if (!op) begin
      xe = (x1 < HD - 1) ? x1 : HD - 1;
      ye = (y1 < VD - 1) ? y1 : VD - 1;
      for (int y = y0; y <= ye; y++)
        for (int x = x0; x <= xe; x++)
          eq.push_back('{x, y, color, 0});
    end
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge sys_clk); g++; end
    rdy_mode = mode; rd_lat = lat; rd_val = val; stray = st;
    @(posedge sys_clk); #1;
    wq.delete(); done_cnt = 0; rdv_cnt = 0; first_req = -1; ra_pend = 1'b0;
    cmd_valid = 1'b1; cmd_op = op;
    cmd_x0 = `H_SIZE'(x0); cmd_x1 = `H_SIZE'(x1);
    cmd_y0 = `V_SIZE'(y0); cmd_y1 = `V_SIZE'(y1);
    cmd_color = RGB_SIZE'(color);
    @(negedge sys_clk);
    acc = cyc;
    chk("cmd_accept_ready", cmd_ready, 1);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    cmd_x0 = `H_SIZE'($urandom); cmd_x1 = `H_SIZE'($urandom);
    cmd_y0 = `V_SIZE'($urandom); cmd_y1 = `V_SIZE'($urandom);
    cmd_color = RGB_SIZE'($urandom); cmd_op = 1'($urandom);
    g = 0;
    while (done_cnt == 0 && g < 3000) begin @(negedge sys_clk); #1; g++; end
    if (done_cnt == 0) chk("done_wait_expired", 0, 1);
    chk("ready_low_during_done", done_rdy, 0);
    @(negedge sys_clk);
    chk("ready_after_done", cmd_ready, 1);
    repeat (3) @(negedge sys_clk);
    #1;
    chk("single_done", done_cnt, 1);
    if (!op) begin
      chk("write_count", wq.size(), eq.size());
      for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
        chk("write_x", wq[i].x, eq[i].x);
        chk("write_y", wq[i].y, eq[i].y);
        chk("write_data", wq[i].d, eq[i].d);
        if (mode == 0) chk("write_cycle", wq[i].c, acc + 1 + i);
      end
      if (eq.size() == 0) begin
        chk("empty_done_cycle", done_cyc, acc + 1);
        chk("empty_no_request", first_req, -1);
      end else begin
        chk("first_write_cycle", first_req, acc + 1);
        if (wq.size() > 0) chk("done_after_last_write", done_cyc, wq[wq.size()-1].c + 1);
      end
      chk("fill_no_rd_valid", rdv_cnt, 0);
    end else begin
      oob = (x0 >= HD) || (y0 >= VD);
      chk("rd_count", rdv_cnt, 1);
      chk("rd_valid_with_done", done_rdv, 1);
      chk("rd_no_writes", wq.size(), 0);
      if (oob) begin
        chk("oob_done_cycle", done_cyc, acc + 1);
        chk("oob_no_request", first_req, -1);
        chk("oob_err", done_rde, 1);
        chk("oob_data", done_rdd, 0);
      end else begin
        chk("read_req_cycle", first_req, acc + 1);
        if (lat > 0) begin
          chk("read_done_cycle", done_cyc, ra_cyc + lat + 1);
          chk("read_err", done_rde, 0);
          chk("read_data", done_rdd, val & 16'hFFFF);
        end else begin
          chk("timeout_window", (done_cyc >= ra_cyc + RD_TIMEOUT) &&
                                (done_cyc <= ra_cyc + RD_TIMEOUT + 2), 1);
          chk("timeout_err", done_rde, 1);
          chk("timeout_data", done_rdd, 0);
        end
      end
    end
    nw   = wq.size();
    lx   = (nw > 0) ? wq[nw-1].x : -1;
    ly   = (nw > 0) ? wq[nw-1].y : -1;
    err  = done_rde;
    rdat = int'(done_rdd);
  endtask

  typedef struct {
    bit op; int x0; int x1; int y0; int y1; int color; int mode; int lat; int val; bit st;
    int exp_n; int exp_lx; int exp_ly; bit exp_err; int exp_rd;
  } vec_t;
  vec_t tv[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nw, lx, ly, rdat, acc, g;
    bit  err;

    //           op  x0   x1   y0   y1  color  md lat  val     st  n    lx   ly   err rd
    tv[0]  = '{0, 10,  11,  20,  21, 'hABC, 0, 0, 0,      0, 4,   11,  21,  0, 0};
    tv[1]  = '{0, 10,  11,  20,  21, 'hABC, 1, 0, 0,      0, 4,   11,  21,  0, 0};
    tv[2]  = '{0, 630, 700, 470, 500, 'h123, 0, 0, 0,     0, 100, 639, 479, 0, 0};
    tv[3]  = '{0, 5,   3,   0,   0,  'h111, 0, 0, 0,      0, 0,   -1,  -1,  0, 0};
    tv[4]  = '{1, 100, 0,   50,  0,  0,     0, 2, 'h0F0F, 0, 0,   -1,  -1,  0, 'h0F0F};
    tv[5]  = '{1, 100, 0,   50,  0,  0,     0, 0, 0,      0, 0,   -1,  -1,  1, 0};
    tv[6]  = '{1, 640, 0,   10,  0,  0,     0, 2, 'h1234, 0, 0,   -1,  -1,  1, 0};
    tv[7]  = '{0, 0,   0,   0,   0,  'hFFF, 2, 0, 0,      1, 1,   0,   0,   0, 0};
    tv[8]  = '{0, 700, 800, 10,  12, 'h222, 0, 0, 0,      0, 0,   -1,  -1,  0, 0};
    tv[9]  = '{0, 3,   4,   480, 490, 'h333, 0, 0, 0,     0, 0,   -1,  -1,  0, 0};
    tv[10] = '{1, 639, 0,   479, 0,  0,     2, 1, 'hBEEF, 1, 0,   -1,  -1,  0, 'hBEEF};
    tv[11] = '{0, 636, 639, 0,   2,  'h7E7, 2, 0, 0,      1, 12,  639, 2,   0, 0};

    done_cnt = 0; rdv_cnt = 0; first_req = -1; ra_pend = 1'b0;

    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_done", done, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_err", rd_err, 0);
    chk("reset_src_req", {src_read, src_write}, 0);
    chk("reset_payload", {rd_data, src_x, src_y, src_writedata}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_cmd(tv[i].op, tv[i].x0, tv[i].x1, tv[i].y0, tv[i].y1, tv[i].color, tv[i].mode,
              tv[i].lat, tv[i].val, tv[i].st, nw, lx, ly, err, rdat);
      chk($sformatf("vec%0d_nwrites", i), nw, tv[i].exp_n);
      chk($sformatf("vec%0d_last_x", i), lx, tv[i].exp_lx);
      chk($sformatf("vec%0d_last_y", i), ly, tv[i].exp_ly);
      if (tv[i].op) begin
        chk($sformatf("vec%0d_rd_err", i), err, tv[i].exp_err);
        chk($sformatf("vec%0d_rd_data", i), rdat, tv[i].exp_rd);
      end
    end

    // Reset lands during the third pixel of a 4x4 fill.
    rdy_mode = 0; stray = 1'b0; rd_lat = 0;
    @(posedge sys_clk); #1;
    wq.delete(); done_cnt = 0;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    cmd_x0 = 200; cmd_x1 = 203; cmd_y0 = 100; cmd_y1 = 103; cmd_color = 'h555;
    @(negedge sys_clk);
    acc = cyc;
    chk("rst_seq_accept", cmd_ready, 1);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk); #1;
    chk("rst_seq_cycle", cyc, acc + 4);
    chk("rst_seq_src_write", src_write, 0);
    chk("rst_seq_outputs", {done, rd_valid, rd_err, src_read, busy, src_x, src_y, src_writedata}, 0);
    chk("rst_seq_writes_before", wq.size(), 3);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    cmd_x0 = 7; cmd_x1 = 7; cmd_y0 = 7; cmd_y1 = 7; cmd_color = 'h321;
    @(negedge sys_clk); #1;
    chk("rst_seq_new_accept", cmd_ready, 1);
    chk("rst_seq_no_done", done_cnt, 0);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    g = 0;
    while (done_cnt == 0 && g < 50) begin @(negedge sys_clk); #1; g++; end
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_seq_single_done", done_cnt, 1);
    chk("rst_seq_done_cycle", done_cyc, acc + 7);
    chk("rst_seq_writes_after", wq.size(), 4);
    if (wq.size() == 4) begin
      chk("rst_seq_new_x", wq[3].x, 7);
      chk("rst_seq_new_y", wq[3].y, 7);
      chk("rst_seq_new_data", wq[3].d, 'h321);
    end

    // Random commands clustered around the clip edges.
    for (int k = 0; k < 40; k++) begin
      bit op_r;
      int x0r, x1r, y0r, y1r;
      op_r = ($urandom_range(0, 3) == 0);
      if (op_r) begin
        x0r = $urandom_range(630, 645);
        y0r = $urandom_range(470, 485);
        run_cmd(1'b1, x0r, 0, y0r, 0, 0, $urandom_range(0, 2), $urandom_range(1, 5),
                int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), nw, lx, ly, err, rdat);
      end else begin
        x0r = $urandom_range(600, 660);
        x1r = ($urandom_range(0, 7) == 0) ? 1023 : x0r + $urandom_range(0, 12) - 2;
        y0r = $urandom_range(460, 490);
        y1r = y0r + $urandom_range(0, 6) - 1;
        if (x1r > 1023) x1r = 1023;
        run_cmd(1'b0, x0r, x1r, y0r, y1r, int'($urandom_range(0, 4095)), $urandom_range(0, 2),
                0, 0, 1'($urandom_range(0, 1)), nw, lx, ly, err, rdat);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
